// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch queue: FSM state encoding and the
// {pc, instr} entry stored in the fetch FIFO.
package fetch_pkg;
    localparam int PC_W    = 5;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_fifo.sv
// Small synchronous FIFO of fetch entries. Clear has priority over push/pop.
// The head reads zero when the FIFO is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     din,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);
    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !clear && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !clear && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues one memory request at a time from the PC,
// buffers {pc, instr} responses for decode, and drops in-flight work on a flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADD_WIDTH   = PC_W,
    parameter int INSTR_WIDTH = INSTR_W,
    parameter int DEPTH       = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [ADD_WIDTH-1:0]   PC_in,
    input  logic                   PC_Ready,
    input  logic                   Flush,
    output logic                   Stall_out,
    output logic                   Imem_Req,
    output logic [ADD_WIDTH-1:0]   Imem_Addr,
    input  logic                   Imem_Gnt,
    input  logic                   Imem_Rvalid,
    input  logic [INSTR_WIDTH-1:0] Imem_Rdata,
    output logic                   ID_Valid,
    output logic [INSTR_WIDTH-1:0] ID_Instr,
    output logic [ADD_WIDTH-1:0]   ID_PC,
    input  logic                   ID_Ready
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t         state;
    fetch_state_t         next_state;
    logic [ADD_WIDTH-1:0] pending_pc;
    logic [CNT_W-1:0]     count;
    fetch_entry_t         head;
    fetch_entry_t         din;
    logic                 outstanding;
    logic                 credit;
    logic                 grant;
    logic                 push;
    logic                 pop;

    assign outstanding = (state != IDLE);
    // Credit uses registered occupancy only; a same-cycle pop is not counted.
    assign credit = ({1'b0, count} + {{CNT_W{1'b0}}, outstanding}) < (CNT_W + 1)'(DEPTH);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            pending_pc <= '0;
        end else begin
            state <= next_state;
            if (grant) pending_pc <= PC_in;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant) next_state = WAIT;
            WAIT:    if (Imem_Rvalid) next_state = grant ? WAIT : IDLE;
            DRAIN:   if (Imem_Rvalid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // A response landing in the flush cycle retires the request, so there is nothing left to drain.
        if (Flush) begin
            next_state = ((outstanding && !Imem_Rvalid) || grant) ? DRAIN : IDLE;
        end
    end

    always_comb begin
        Imem_Req = 1'b0;
        if (!Rst && !Flush && PC_Ready && credit &&
            (state == IDLE || (state == WAIT && Imem_Rvalid))) begin
            Imem_Req = 1'b1;
        end
        grant     = Imem_Req && Imem_Gnt;
        Stall_out = !(grant || Flush);
        push      = (state == WAIT) && Imem_Rvalid && !Flush;
        pop       = ID_Valid && ID_Ready && !Flush;
    end

    assign din = '{pc: PC_W'(pending_pc), instr: INSTR_W'(Imem_Rdata)};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (push),
        .pop   (pop),
        .clear (Flush),
        .din   (din),
        .count (count),
        .head  (head)
    );

    assign Imem_Addr = PC_in;
    assign ID_Valid  = (count != '0);
    assign ID_Instr  = INSTR_WIDTH'(head.instr);
    assign ID_PC     = ADD_WIDTH'(head.pc);
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, compared with
// a queue-based model of PC, memory and decode behaviour.
module tb_fetch_queue;
    localparam int AW    = 5;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [AW-1:0] PC_in = '0;
    logic          PC_Ready = 1'b0;
    logic          Flush = 1'b0;
    logic          Stall_out;
    logic          Imem_Req;
    logic [AW-1:0] Imem_Addr;
    logic          Imem_Gnt = 1'b0;
    logic          Imem_Rvalid = 1'b0;
    logic [IW-1:0] Imem_Rdata = '0;
    logic          ID_Valid;
    logic [IW-1:0] ID_Instr;
    logic [AW-1:0] ID_PC;
    logic          ID_Ready = 1'b0;

    fetch_queue #(.ADD_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .PC_in(PC_in), .PC_Ready(PC_Ready), .Flush(Flush),
        .Stall_out(Stall_out), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
        .Imem_Gnt(Imem_Gnt), .Imem_Rvalid(Imem_Rvalid), .Imem_Rdata(Imem_Rdata),
        .ID_Valid(ID_Valid), .ID_Instr(ID_Instr), .ID_PC(ID_PC), .ID_Ready(ID_Ready)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } ent_t;

    ent_t          q[$];
    bit            m_out;
    bit            m_drop;
    int            m_lat;
    int            lat_sel = 1;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_opc;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, then advance the model.
    task automatic step(input bit fl, input bit rdy, input bit gn, input bit idr,
                        input logic [AW-1:0] tgt, input bit stale);
        bit            mem_rv;
        bit            rv;
        bit            req_e;
        bit            gr_e;
        logic [IW-1:0] rdata;
        mem_rv   = m_out && (m_lat == 0);
        rv       = mem_rv || stale;
        rdata    = $urandom;
        Flush    = fl;
        PC_Ready = rdy;
        Imem_Gnt = gn;
        ID_Ready = idr;
        Imem_Rvalid = rv;
        Imem_Rdata  = rdata;
        PC_in    = m_pc;
        #1;
        req_e = !fl && rdy && ((q.size() + int'(m_out)) < DEPTH) &&
                (!m_out || (!m_drop && mem_rv));
        gr_e  = req_e && gn;
        chk("imem_req",  32'(Imem_Req),  32'(req_e));
        chk("stall_out", 32'(Stall_out), 32'(!(gr_e || fl)));
        chk("imem_addr", 32'(Imem_Addr), 32'(m_pc));
        chk("id_valid",  32'(ID_Valid),  32'(q.size() != 0));
        chk("id_pc",     32'(ID_PC),     (q.size() != 0) ? 32'(q[0].pc) : 32'd0);
        chk("id_instr",  ID_Instr,       (q.size() != 0) ? q[0].instr : 32'd0);
        @(posedge Clk);
        if (fl) begin
            q.delete();
            if (m_out) begin
                if (mem_rv) m_out = 1'b0;
                else        m_drop = 1'b1;
            end
            m_pc = tgt;
        end else begin
            if (m_out && mem_rv) begin
                if (!m_drop) begin
                    chk("push_not_full", 32'(q.size() < DEPTH), 32'd1);
                end
            end
            if (q.size() != 0 && idr) void'(q.pop_front());
            if (m_out && mem_rv) begin
                if (!m_drop) q.push_back('{pc: m_opc, instr: rdata});
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_lat--;
            end
            if (gr_e) begin
                m_out  = 1'b1;
                m_drop = 1'b0;
                m_opc  = m_pc;
                m_lat  = lat_sel - 1;
                m_pc   = m_pc + AW'(4);
            end
        end
        #1;
    endtask

    initial begin
        q.delete();
        m_out = 1'b0; m_drop = 1'b0; m_lat = 0; m_pc = '0; m_opc = '0;
        PC_Ready = 1'b1;
        #12;
        chk("rst_id_valid",  32'(ID_Valid),  32'd0);
        chk("rst_id_instr",  ID_Instr,       32'd0);
        chk("rst_id_pc",     32'(ID_PC),     32'd0);
        chk("rst_imem_req",  32'(Imem_Req),  32'd0);
        chk("rst_stall_out", 32'(Stall_out), 32'd1);
        @(posedge Clk); #1;
        Rst = 1'b0;

        // Streaming fetch, single-cycle memory, decode always ready.
        lat_sel = 1;
        for (int i = 0; i < 10; i++) step(0, 1, 1, 1, '0, 0);
        // Decode back-pressure fills the queue, then releases.
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, '0, 0);
        // Grant withheld for three cycles.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, '0, 0);
        // Flush with a request in flight, then fetch from the jump target.
        lat_sel = 2;
        step(0, 1, 1, 0, '0, 0);
        step(1, 1, 1, 1, 5'h10, 0);
        lat_sel = 1;
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, '0, 0);
        // Flush together with a pop.
        step(0, 1, 1, 0, '0, 0);
        step(1, 1, 1, 1, 5'h08, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, '0, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            lat_sel = int'($urandom_range(1, 3));
            step(($urandom_range(0, 11) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 AW'($urandom), 0);
        end

        // Reset in the middle of a pending request, then a stale response.
        lat_sel = 3;
        step(0, 1, 1, 0, '0, 0);
        while (!m_out) step(0, 1, 1, 0, '0, 0);
        Rst = 1'b1;
        #2;
        chk("midrst_id_valid",  32'(ID_Valid),  32'd0);
        chk("midrst_imem_req",  32'(Imem_Req),  32'd0);
        chk("midrst_stall_out", 32'(Stall_out), 32'd1);
        chk("midrst_id_pc",     32'(ID_PC),     32'd0);
        q.delete();
        m_out = 1'b0; m_drop = 1'b0; m_lat = 0; m_pc = '0;
        @(posedge Clk); #1;
        Rst = 1'b0;
        step(0, 0, 1, 1, '0, 1);
        step(0, 0, 1, 1, '0, 0);
        lat_sel = 1;
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
